// File: rtl/ibex_ifetch_arbiter_if.sv
// Bus bundle for the instruction-fetch arbiter: two requester channels on one
// side, the single pipelined req/gnt/rvalid instruction-memory port on the other.
interface ibex_ifetch_arbiter_if #(
  parameter int MaxOutstanding = 2
);
  localparam int CntW = $clog2(MaxOutstanding + 1);

  // requester side
  logic [1:0]      req_i;
  logic [63:0]     addr_i;
  logic [1:0]      gnt_o;
  logic [1:0]      rvalid_o;
  logic [31:0]     rdata_o;
  logic            err_o;

  // instruction-memory side
  logic            instr_req_o;
  logic [31:0]     instr_addr_o;
  logic            instr_gnt_i;
  logic [31:0]     instr_rdata_i;
  logic            instr_err_i;
  logic            instr_rvalid_i;

  // status
  logic [CntW-1:0] outstanding_o;
  logic            busy_o;

  // arbiter view
  modport slave (
    input  req_i, addr_i, instr_gnt_i, instr_rdata_i, instr_err_i, instr_rvalid_i,
    output gnt_o, rvalid_o, rdata_o, err_o, instr_req_o, instr_addr_o,
           outstanding_o, busy_o
  );

  // environment view (requesters plus memory)
  modport master (
    output req_i, addr_i, instr_gnt_i, instr_rdata_i, instr_err_i, instr_rvalid_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, instr_req_o, instr_addr_o,
           outstanding_o, busy_o
  );
endinterface

// File: rtl/ibex_ifetch_arbiter.sv
// Two-requester round-robin arbiter for the instruction-memory port.
// A stalled request is locked to its owner until granted; every grant records
// its owner in an in-order queue so responses are routed back in grant order.
// Reset is also applied to the combinational handshake outputs, so the bus is
// quiet for as long as rst_i is high.
module ibex_ifetch_arbiter #(
  parameter int MaxOutstanding = 2
) (
  input logic                  clk_i,
  input logic                  rst_i,
  ibex_ifetch_arbiter_if.slave bus
);

  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

  logic [CntW-1:0]           count;
  logic [PtrW-1:0]           wr_ptr;
  logic [PtrW-1:0]           rd_ptr;
  logic [MaxOutstanding-1:0] owner_q;
  logic                      lock;
  logic                      lock_owner;
  logic                      prio;

  logic                      can_issue;
  logic                      sel;
  logic                      sel_valid;
  logic                      req_out;
  logic                      grant;
  logic                      pop;
  logic                      head_owner;
  logic [31:0]               sel_addr;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  // Issue is limited only by queue occupancy, never by the response strobe.
  assign can_issue = (count < CntMax);

  // Pick a requester: the lock owner if locked, otherwise round-robin among askers.
  always_comb begin
    sel       = 1'b0;
    sel_valid = 1'b0;
    if (lock) begin
      sel       = lock_owner;
      sel_valid = 1'b1;
    end else begin
      unique case (bus.req_i)
        2'b01: begin
          sel       = 1'b0;
          sel_valid = 1'b1;
        end
        2'b10: begin
          sel       = 1'b1;
          sel_valid = 1'b1;
        end
        2'b11: begin
          sel       = prio;
          sel_valid = 1'b1;
        end
        default: begin
          sel       = 1'b0;
          sel_valid = 1'b0;
        end
      endcase
    end
  end

  assign req_out    = ~rst_i & can_issue & sel_valid & bus.req_i[sel];
  assign grant      = req_out & bus.instr_gnt_i;
  assign pop        = ~rst_i & bus.instr_rvalid_i & (count != '0);
  assign head_owner = owner_q[rd_ptr];
  assign sel_addr   = sel ? bus.addr_i[63:32] : bus.addr_i[31:0];

  // Downstream request and same-cycle grant/response routing.
  always_comb begin
    bus.instr_req_o  = req_out;
    bus.instr_addr_o = {sel_addr[31:2], 2'b00};
    bus.gnt_o        = 2'b00;
    bus.rvalid_o     = 2'b00;
    if (grant) begin
      bus.gnt_o = sel ? 2'b10 : 2'b01;
    end
    if (pop) begin
      bus.rvalid_o = head_owner ? 2'b10 : 2'b01;
    end
    bus.rdata_o       = bus.instr_rdata_i;
    bus.err_o         = bus.instr_err_i;
    bus.outstanding_o = count;
    bus.busy_o        = (count != '0) | req_out;
  end

  // Owner queue: push the selected requester on grant, pop on a routed response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      owner_q <= '0;
    end else begin
      if (grant) begin
        owner_q[wr_ptr] <= sel;
        wr_ptr          <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      unique case ({grant, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Lock holds a stalled selection until granted or abandoned by its requester.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock       <= 1'b0;
      lock_owner <= 1'b0;
    end else if (grant) begin
      lock <= 1'b0;
    end else if (lock && !bus.req_i[lock_owner]) begin
      lock <= 1'b0;
    end else if (req_out) begin
      lock       <= 1'b1;
      lock_owner <= sel;
    end
  end

  // Round-robin pointer moves to the other requester after every grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio <= 1'b0;
    end else if (grant) begin
      prio <= ~sel;
    end
  end

endmodule

// File: tb/tb_ibex_ifetch_arbiter.sv
// Self-checking bench: per-cycle comparison against a queue-based reference
// model, plus an independent monitor that checks response ownership in order.
module tb_ibex_ifetch_arbiter;
  localparam int MaxO = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ibex_ifetch_arbiter_if #(.MaxOutstanding(MaxO)) bus ();
  ibex_ifetch_arbiter #(.MaxOutstanding(MaxO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  bit m_q[$];
  bit m_lock;
  bit m_owner;
  bit m_prio;
  bit sb[$];
  int env_pend = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive at negedge, compare after settling, advance the model.
  task automatic step(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                      input logic g, input logic rv);
    logic [31:0] rd;
    logic        er;
    bit          have, s, ereq, egr, epop;
    logic [31:0] ea;
    @(negedge clk);
    rd = $urandom;
    er = 1'($urandom_range(0, 1));
    bus.req_i          = req;
    bus.addr_i         = {a1, a0};
    bus.instr_gnt_i    = g;
    bus.instr_rvalid_i = rv;
    bus.instr_rdata_i  = rd;
    bus.instr_err_i    = er;
    #1;
    have = 1'b1;
    s    = 1'b0;
    if (m_lock)            s = m_owner;
    else if (req == 2'b01) s = 1'b0;
    else if (req == 2'b10) s = 1'b1;
    else if (req == 2'b11) s = m_prio;
    else                   have = 1'b0;
    ereq = (m_q.size() < MaxO) && have && req[s];
    egr  = ereq && g;
    epop = rv && (m_q.size() != 0);
    ea   = s ? a1 : a0;
    chk("instr_req", bus.instr_req_o, ereq);
    chk("gnt", bus.gnt_o, egr ? (s ? 2'b10 : 2'b01) : 2'b00);
    chk("rvalid", bus.rvalid_o, epop ? (m_q[0] ? 2'b10 : 2'b01) : 2'b00);
    chk("outstanding", bus.outstanding_o, m_q.size());
    chk("busy", bus.busy_o, (m_q.size() != 0) || ereq);
    chk("rdata", bus.rdata_o, rd);
    chk("err", bus.err_o, er);
    if (ereq) chk("instr_addr", bus.instr_addr_o, {ea[31:2], 2'b00});
    if (egr) sb.push_back(s);
    if (bus.instr_req_o && g) env_pend++;
    if (rv && env_pend > 0) env_pend--;
    if (epop) void'(m_q.pop_front());
    if (egr) begin
      m_q.push_back(s);
      m_prio = !s;
    end
    if (egr)                           m_lock = 1'b0;
    else if (m_lock && !req[m_owner])  m_lock = 1'b0;
    else if (ereq && !g) begin
      m_lock  = 1'b1;
      m_owner = s;
    end
  endtask

  task automatic idle_inputs();
    bus.req_i = 2'b00; bus.addr_i = '0; bus.instr_gnt_i = 1'b0;
    bus.instr_rvalid_i = 1'b0; bus.instr_rdata_i = '0; bus.instr_err_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("rst_gnt", bus.gnt_o, 2'b00);
    chk("rst_rvalid", bus.rvalid_o, 2'b00);
    chk("rst_instr_req", bus.instr_req_o, 1'b0);
    chk("rst_outstanding", bus.outstanding_o, 0);
    chk("rst_busy", bus.busy_o, 1'b0);
    m_q.delete();
    sb.delete();
    m_lock = 1'b0;
    m_prio = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (env_pend > 0 || m_q.size() > 0); i++) step(2'b00, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic rstep();
    logic rv;
    if (env_pend > 0) rv = 1'($urandom_range(0, 1));
    else              rv = ($urandom_range(0, 7) == 0);
    step(2'($urandom), $urandom, $urandom, 1'($urandom_range(0, 3) != 0), rv);
  endtask

  // Monitor: every routed response must belong to the oldest outstanding grant.
  initial begin
    bit exp;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b0 && bus.rvalid_o != 2'b00) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_empty: got rvalid_o=%b expected none at %0t", bus.rvalid_o, $time);
        end else begin
          exp = sb.pop_front();
          chk("sb_owner", bus.rvalid_o, exp ? 2'b10 : 2'b01);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_lock = 1'b0; m_owner = 1'b0; m_prio = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // single requester streaming
    step(2'b01, 32'h100, 32'h0, 1'b1, 1'b0);
    step(2'b01, 32'h104, 32'h0, 1'b1, 1'b1);
    step(2'b01, 32'h108, 32'h0, 1'b1, 1'b1);
    step(2'b00, 32'h0,   32'h0, 1'b1, 1'b1);
    drain();

    // contention round-robin from reset
    do_reset();
    step(2'b11, 32'h200, 32'h300, 1'b1, 1'b0);
    step(2'b11, 32'h204, 32'h304, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(2'b11, 32'h208 + 4 * i, 32'h308 + 4 * i, 1'b1, 1'b1);
    drain();

    // lock under stall: pointer first moved to requester 1
    step(2'b01, 32'h400, 32'h500, 1'b1, 1'b0);
    drain();
    for (int i = 0; i < 3; i++) step(2'b01, 32'h410, 32'h510, 1'b0, 1'b0);
    step(2'b11, 32'h410, 32'h510, 1'b1, 1'b0);
    step(2'b11, 32'h410, 32'h510, 1'b1, 1'b1);
    drain();

    // full queue, resume after pop, push+pop together
    for (int i = 0; i < 3; i++) step(2'b01, 32'h600 + 4 * i, 32'h0, 1'b1, 1'b0);
    step(2'b01, 32'h60c, 32'h0, 1'b1, 1'b1);
    step(2'b01, 32'h60c, 32'h0, 1'b1, 1'b1);
    step(2'b01, 32'h610, 32'h0, 1'b1, 1'b1);
    drain();

    // spurious response
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);

    // reset with transactions outstanding, late responses dropped
    step(2'b10, 32'h0, 32'h700, 1'b1, 1'b0);
    step(2'b01, 32'h704, 32'h0, 1'b1, 1'b0);
    do_reset();
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    env_pend = 0;

    // misaligned address
    step(2'b01, 32'h0000_0106, 32'h0, 1'b1, 1'b0);
    step(2'b10, 32'h0, 32'h0000_0203, 1'b1, 1'b1);
    drain();

    // randomized traffic
    for (int i = 0; i < 400; i++) rstep();
    drain();

    @(negedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_ifetch_arbiter.md
Name: ibex_ifetch_arbiter

Overview:
Two-requester arbiter for the core's single instruction-memory port, using the pipelined req/gnt/rvalid protocol. Requester 0 is the prefetch buffer; requester 1 is a secondary fetcher, e.g. a debug/ROM or refill engine.
- Arbitrates requests round-robin.
- Holds the selection stable until the downstream grant.
- Records the owner of every granted transaction in an in-order queue.
- Routes each response back to that transaction's owner.

Parameters:
MaxOutstanding, 2, maximum granted-but-unanswered transactions (owner queue depth, >=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_i  in  2  per-requester request; bit n = requester n
addr_i  in  64  per-requester word address; [32n+31:32n] = requester n
gnt_o  out  2  per-requester grant, one-hot or zero
rvalid_o  out  2  per-requester response valid, one-hot or zero
rdata_o  out  32  response data, broadcast to both requesters
err_o  out  1  response error, broadcast to both requesters
instr_req_o  out  1  downstream request
instr_addr_o  out  32  downstream address, bits [1:0] forced to 0
instr_gnt_i  in  1  downstream grant
instr_rdata_i  in  32  downstream data
instr_err_i  in  1  downstream error
instr_rvalid_i  in  1  downstream response valid
outstanding_o  out  $clog2(MaxOutstanding+1)  current owner-queue fill count
busy_o  out  1  high when outstanding_o != 0 or instr_req_o is high

Behaviour:
- Reset values: gnt_o=0, rvalid_o=0, instr_req_o=0, outstanding_o=0, busy_o=0. Lock is clear. Owner queue is empty. Priority pointer = requester 0.
- Issue enable: can_issue = (count < MaxOutstanding). The enable does not depend on instr_rvalid_i, so there is no combinational path from rvalid to req.
- Selection when unlocked:
  - Only one requester has req_i high: select it.
  - Both have req_i high: select the requester named by the priority pointer.
  - Neither has req_i high: no selection.
- Selection when locked: the locked owner is selected regardless of the other requester.
- Downstream request: instr_req_o = can_issue & selected requester's req_i. instr_addr_o = selected address with bits [1:0] cleared. The path is purely combinational, with zero added latency.
- Grant: gnt_o[sel] = instr_req_o & instr_gnt_i, in the same cycle.
- Lock:
  - Set at the clock edge when instr_req_o=1 and instr_gnt_i=0; lock owner = sel.
  - Cleared on the grant edge.
  - Also cleared if the locked requester drops req_i. The arbitration then reruns the next cycle. Dropping the request is a requester protocol violation; the arbiter does not hold the address.
- Priority pointer: on each grant it is set to the other requester (1 - sel). It does not change otherwise.
- Owner queue:
  - Circular FIFO of 1-bit owner IDs, MaxOutstanding deep.
  - Push sel on a grant. Pop on instr_rvalid_i when count != 0.
  - Push and pop in the same cycle: count unchanged, pointers advance and wrap modulo MaxOutstanding.
- Response routing:
  - rvalid_o[head] = instr_rvalid_i & (count != 0), combinational and same-cycle.
  - rdata_o = instr_rdata_i and err_o = instr_err_i at all times.
- Spurious rvalid (count == 0): dropped. rvalid_o stays 0 and the queue is unchanged.
- Full queue (count == MaxOutstanding): instr_req_o=0 and gnt_o=0. A lock set earlier persists. Issue resumes the cycle after a pop.
- Reset mid-operation: the queue, lock and pointer are cleared asynchronously. Responses still in flight downstream then arrive with count==0 and are dropped as spurious.
- Ordering: responses return in grant order. A requester never receives an rvalid for another requester's transaction.

Test Plan:
- Single requester streaming: req_i=01, gnt tied high, rvalid one cycle after each grant, addrs 0x100,0x104,0x108 -> gnt_o=01 each cycle, rvalid_o=01 each response, instr_addr_o matches, outstanding_o never exceeds 1.
- Contention round-robin: req_i=11 held, gnt high every cycle, responses delayed -> grants alternate 0,1,0,1 starting with requester 0 after reset; rvalid_o sequence 01,10,01,10 matches grant order.
- Lock under stall: req_i=01 with instr_gnt_i=0 for 3 cycles, then req_i=11 with gnt high -> requester 0 is granted first even though it is not selected by the pointer; addr stable throughout the stall; then requester 1 is granted.
- Full queue, MaxOutstanding=2: two grants with no rvalid -> instr_req_o=0, outstanding_o=2. One rvalid -> outstanding_o=1 and instr_req_o re-asserts the next cycle. Push and pop in the same cycle keep the count at 1.
- Spurious and reset: rvalid with empty queue -> rvalid_o=00, outstanding_o=0. Assert rst_i with 2 outstanding -> outputs zero immediately; later rvalids are dropped.
- Misaligned address: addr_i[31:0]=0x0000_0106 -> instr_addr_o=0x0000_0104.
